// File: rtl/lpddr4_arb_ctrl.sv
// Two-port round-robin arbiter and command sequencer for the LPDDR4 dummy
// memory model. Byte-strobed partial writes become read-modify-write
// sequences because the memory always writes whole words.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   pN_req/we/addr/wdata/wstrb  requester N command (held until pN_gnt)
//   pN_gnt                 accept pulse, asserted in the IDLE cycle that
//                          takes the request
//   pN_done, pN_rdata      completion pulse; read data valid with done
//   busy                   high whenever the sequencer is not idle
//   cs, ras, cas, we       active-low memory command pins
//   addr, ba               memory word address and bank
//   dq, dm, dqs            data bus (driven only while writing), mask, strobe
module lpddr4_arb_ctrl #(
  parameter int unsigned BA_LSB = 16,
  parameter bit          RMW_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  input  logic [3:0]  p0_wstrb,
  output logic        p0_gnt,
  output logic        p0_done,
  output logic [31:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  input  logic [3:0]  p1_wstrb,
  output logic        p1_gnt,
  output logic        p1_done,
  output logic [31:0] p1_rdata,
  output logic        busy,
  output logic        cs,
  output logic        ras,
  output logic        cas,
  output logic        we,
  output logic [13:0] addr,
  output logic [2:0]  ba,
  inout  wire  [31:0] dq,
  output logic [3:0]  dm,
  output logic        dqs
);

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 4;
  localparam int unsigned MW = 14;
  localparam int unsigned BW = 3;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RD_CMD = 3'd1,
    RD_CAP = 3'd2,
    MERGE  = 3'd3,
    WR_CMD = 3'd4,
    RESP   = 3'd5
  } state_t;

  state_t state, nxt;

  // Latched transaction
  logic          rr;        // 0: port 0 wins a tie, 1: port 1 wins
  logic          op_port;
  logic          op_wr;
  logic [MW-1:0] op_word;
  logic [BW-1:0] op_ba;
  logic [DW-1:0] op_wdata;
  logic [SW-1:0] op_wstrb;
  logic [DW-1:0] cap;

  logic          dq_oe;
  logic [DW-1:0] dq_out;

  // Arbitration and selected-port view
  logic          take;
  logic          sel;
  logic          sel_we;
  logic [DW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic [SW-1:0] sel_wstrb;

  // Values the command registers load at the next edge
  logic          cmd_port;
  logic [MW-1:0] cmd_word;
  logic [BW-1:0] cmd_ba;
  logic [DW-1:0] cmd_wdata;
  logic [SW-1:0] cmd_wstrb;
  logic [DW-1:0] merged;
  logic          nxt_cmd;

  // Address bits outside the word/bank fields alias by design
  logic unused_addr;
  assign unused_addr = ^{p0_addr, p1_addr};

  assign sel_we    = sel ? p1_we    : p0_we;
  assign sel_addr  = sel ? p1_addr  : p0_addr;
  assign sel_wdata = sel ? p1_wdata : p0_wdata;
  assign sel_wstrb = sel ? p1_wstrb : p0_wstrb;

  // Round-robin pick; only an idle, out-of-reset sequencer grants
  always_comb begin
    take = 1'b0;
    sel  = 1'b0;
    if (rst_n && state == IDLE) begin
      if (p0_req && (!p1_req || !rr)) begin
        take = 1'b1;
        sel  = 1'b0;
      end else if (p1_req) begin
        take = 1'b1;
        sel  = 1'b1;
      end
    end
  end

  assign p0_gnt = take & ~sel;
  assign p1_gnt = take & sel;

  assign cmd_port  = take ? sel : op_port;
  assign cmd_word  = take ? sel_addr[15:2] : op_word;
  assign cmd_ba    = take ? sel_addr[BA_LSB+2:BA_LSB] : op_ba;
  assign cmd_wdata = take ? sel_wdata : op_wdata;
  assign cmd_wstrb = take ? sel_wstrb : op_wstrb;
  assign nxt_cmd   = (nxt == RD_CMD) || (nxt == WR_CMD);

  // Byte merge of the new write data over the captured word
  always_comb begin
    merged = cap;
    for (int i = 0; i < int'(SW); i++) begin
      if (op_wstrb[i]) merged[i*8 +: 8] = op_wdata[i*8 +: 8];
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE: begin
        if (take) begin
          if (sel_we && sel_wstrb == 4'h0)                    nxt = RESP;
          else if (!sel_we || (RMW_EN && sel_wstrb != 4'hF))  nxt = RD_CMD;
          else                                                nxt = WR_CMD;
        end
      end
      RD_CMD:  nxt = RD_CAP;
      RD_CAP:  nxt = op_wr ? MERGE : RESP;
      MERGE:   nxt = WR_CMD;
      WR_CMD:  nxt = RESP;
      RESP:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Transaction latch, capture, and registered memory/requester outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr       <= 1'b0;
      op_port  <= 1'b0;
      op_wr    <= 1'b0;
      op_word  <= '0;
      op_ba    <= '0;
      op_wdata <= '0;
      op_wstrb <= '0;
      cap      <= '0;
      cs       <= 1'b1;
      ras      <= 1'b1;
      cas      <= 1'b1;
      we       <= 1'b1;
      addr     <= '0;
      ba       <= '0;
      dq_oe    <= 1'b0;
      dq_out   <= '0;
      dm       <= '0;
      dqs      <= 1'b0;
      p0_done  <= 1'b0;
      p1_done  <= 1'b0;
      p0_rdata <= '0;
      p1_rdata <= '0;
      busy     <= 1'b0;
    end else begin
      if (take) begin
        rr       <= ~sel;
        op_port  <= sel;
        op_wr    <= sel_we;
        op_word  <= sel_addr[15:2];
        op_ba    <= sel_addr[BA_LSB+2:BA_LSB];
        op_wdata <= sel_wdata;
        op_wstrb <= sel_wstrb;
      end

      // Memory drives dq during RD_CAP; sample at the edge that ends it
      if (state == RD_CAP) begin
        cap <= dq;
        if (!op_wr && !op_port) p0_rdata <= dq;
        if (!op_wr &&  op_port) p1_rdata <= dq;
      end

      cs  <= ~nxt_cmd;
      ras <= ~nxt_cmd;
      cas <= ~nxt_cmd;
      we  <= ~(nxt == WR_CMD);
      if (nxt_cmd) begin
        addr <= cmd_word;
        ba   <= cmd_ba;
      end

      dq_oe <= (nxt == WR_CMD);
      dqs   <= (nxt == WR_CMD);
      if (nxt == WR_CMD) begin
        dq_out <= (state == MERGE) ? merged : cmd_wdata;
        dm     <= (state == MERGE) ? 4'h0 : ~cmd_wstrb;
      end else begin
        dm     <= 4'h0;
      end

      p0_done <= (nxt == RESP) && !cmd_port;
      p1_done <= (nxt == RESP) &&  cmd_port;
      busy    <= (nxt != IDLE);
    end
  end

  assign dq = dq_oe ? dq_out : {DW{1'bz}};

endmodule

// File: tb/tb_lpddr4_arb_ctrl.sv
// Bench for lpddr4_arb_ctrl: word memory model on the command pins, a
// word-level expected-memory model, directed scenarios and a random mix.
module tb_lpddr4_arb_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [3:0]  p0_wstrb, p1_wstrb;
  logic        p0_gnt, p0_done, p1_gnt, p1_done;
  logic [31:0] p0_rdata, p1_rdata;
  logic        busy, cs, ras, cas, we, dqs;
  logic [13:0] addr;
  logic [2:0]  ba;
  logic [3:0]  dm;
  wire  [31:0] dq;

  int checks = 0;
  int errors = 0;

  lpddr4_arb_ctrl #(.BA_LSB(16), .RMW_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_wstrb(p0_wstrb), .p0_gnt(p0_gnt), .p0_done(p0_done), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_wstrb(p1_wstrb), .p1_gnt(p1_gnt), .p1_done(p1_done), .p1_rdata(p1_rdata),
    .busy(busy), .cs(cs), .ras(ras), .cas(cas), .we(we),
    .addr(addr), .ba(ba), .dq(dq), .dm(dm), .dqs(dqs)
  );

  always #5 clk = ~clk;

  // Memory model: whole-word writes, read data on dq the cycle after a read
  logic [31:0] mem [0:16383];
  logic [31:0] exp_mem [0:16383];
  logic        mem_oe = 1'b0;
  logic [31:0] mem_q = '0;
  logic        pl_en = 1'b0;
  logic [13:0] pl_addr = '0;
  logic [31:0] pl_data = '0;

  assign dq = mem_oe ? mem_q : 32'bz;

  always @(posedge clk) begin
    mem_oe <= 1'b0;
    if (pl_en) mem[pl_addr] <= pl_data;
    if (!cs && !ras && !cas && we) begin
      mem_oe <= 1'b1;
      mem_q  <= mem[addr];
    end
    if (!cs && !ras && !cas && !we) mem[addr] <= dq;
  end

  // Per-cycle snapshot of the last transaction, index = cycles after gnt
  logic [3:0]  cyc_pins [0:19];
  logic [31:0] cyc_dq   [0:19];
  logic        cyc_dqs  [0:19];
  logic [3:0]  cyc_dm   [0:19];
  logic [13:0] cyc_addr [0:19];
  bit          cmd_seen;
  bit          other_done;

  function automatic logic [31:0] merge_w(input logic [31:0] old_w,
                                          input logic [31:0] new_w,
                                          input logic [3:0]  s);
    logic [31:0] r;
    r = old_w;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
    return r;
  endfunction

  function automatic int exp_lat(input bit w, input logic [3:0] s);
    if (!w) return 3;
    if (s == 4'h0) return 1;
    if (s == 4'hF) return 2;
    return 5;
  endfunction

  task automatic preload(input logic [13:0] a, input logic [31:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    exp_mem[a] = d;
  endtask

  task automatic drive_port(input bit port, input bit r, input bit w,
                            input logic [31:0] a, input logic [31:0] d,
                            input logic [3:0] s);
    if (port) begin
      p1_req = r; p1_we = w; p1_addr = a; p1_wdata = d; p1_wstrb = s;
    end else begin
      p0_req = r; p0_we = w; p0_addr = a; p0_wdata = d; p0_wstrb = s;
    end
  endtask

  // One transaction; lat = done cycle after gnt, -1 on timeout
  task automatic do_txn(input bit port, input bit w, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        output int lat, output logic [31:0] rd);
    int n;
    lat = -1; rd = 'x; cmd_seen = 0; other_done = 0;
    @(negedge clk);
    drive_port(port, 1'b1, w, a, d, s);
    #1;
    n = 0;
    while (!(port ? p1_gnt : p0_gnt) && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!(port ? p1_gnt : p0_gnt)) begin
      drive_port(port, 1'b0, w, a, d, s);
      return;
    end
    cyc_pins[0] = {cs, ras, cas, we};
    @(posedge clk); #1;
    drive_port(port, 1'b0, w, a, d, s);
    for (int c = 1; c < 20; c++) begin
      @(negedge clk);
      cyc_pins[c] = {cs, ras, cas, we};
      cyc_dq[c] = dq; cyc_dqs[c] = dqs; cyc_dm[c] = dm; cyc_addr[c] = addr;
      if (!cs) cmd_seen = 1;
      if (port ? p0_done : p1_done) other_done = 1;
      if (port ? p1_done : p0_done) begin
        lat = c;
        rd = port ? p1_rdata : p0_rdata;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_port(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_port(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (3) @(negedge clk);
    checks++;
    if ({cs, ras, cas, we, dqs, busy, p0_gnt, p1_gnt, p0_done, p1_done} !== 10'b1111000000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 1111000000",
               {cs, ras, cas, we, dqs, busy, p0_gnt, p1_gnt, p0_done, p1_done});
    end
    checks++;
    if ({addr, ba, dm} !== 21'h0) begin
      errors++; $display("FAIL reset_addr: addr=%h ba=%h dm=%h want 0", addr, ba, dm);
    end
    checks++;
    if (p0_rdata !== 32'h0 || p1_rdata !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: %h %h want 0", p0_rdata, p1_rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_single_read();
    int lat; logic [31:0] rd;
    preload(14'h0010, 32'hDEADBEEF);
    do_txn(1'b0, 1'b0, 32'h0000_0040, '0, 4'h0, lat, rd);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL read_latency: got %0d want 3", lat); end
    checks++;
    if (cyc_pins[1] !== 4'b0001 || cyc_addr[1] !== 14'h0010) begin
      errors++;
      $display("FAIL read_cmd: pins=%b addr=%h want 0001 0010", cyc_pins[1], cyc_addr[1]);
    end
    checks++;
    if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL read_data: got %h want deadbeef", rd); end
  endtask

  task automatic test_full_write_read();
    int lat; logic [31:0] rd;
    do_txn(1'b1, 1'b1, 32'h0000_0100, 32'h12345678, 4'hF, lat, rd);
    exp_mem[14'h0040] = 32'h12345678;
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", lat); end
    checks++;
    if (cyc_pins[1] !== 4'b0000 || cyc_dq[1] !== 32'h12345678 || cyc_dqs[1] !== 1'b1 ||
        cyc_dm[1] !== 4'h0) begin
      errors++;
      $display("FAIL wr_cmd: pins=%b dq=%h dqs=%b dm=%h want 0000 12345678 1 0",
               cyc_pins[1], cyc_dq[1], cyc_dqs[1], cyc_dm[1]);
    end
    do_txn(1'b1, 1'b0, 32'h0000_0100, '0, 4'h0, lat, rd);
    checks++;
    if (lat !== 3 || rd !== 32'h12345678) begin
      errors++; $display("FAIL wr_readback: lat=%0d data=%h want 3 12345678", lat, rd);
    end
  endtask

  task automatic test_rmw();
    int lat; logic [31:0] rd;
    preload(14'h0040, 32'hAABBCCDD);
    do_txn(1'b1, 1'b1, 32'h0000_0100, 32'h11223344, 4'b0101, lat, rd);
    exp_mem[14'h0040] = merge_w(32'hAABBCCDD, 32'h11223344, 4'b0101);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL rmw_latency: got %0d want 5", lat); end
    checks++;
    if (cyc_pins[1] !== 4'b0001 || cyc_pins[3] !== 4'b1111 || cyc_pins[4] !== 4'b0000 ||
        cyc_dq[4] !== 32'hAA22CC44 || cyc_dm[4] !== 4'h0) begin
      errors++;
      $display("FAIL rmw_seq: p1=%b p3=%b p4=%b dq=%h dm=%h want 0001 1111 0000 aa22cc44 0",
               cyc_pins[1], cyc_pins[3], cyc_pins[4], cyc_dq[4], cyc_dm[4]);
    end
    do_txn(1'b0, 1'b0, 32'h0000_0100, '0, 4'h0, lat, rd);
    checks++;
    if (rd !== 32'hAA22CC44) begin errors++; $display("FAIL rmw_readback: got %h want aa22cc44", rd); end
  endtask

  task automatic test_zero_strobe();
    int lat; logic [31:0] rd;
    do_txn(1'b0, 1'b1, 32'h0000_0100, 32'hFFFFFFFF, 4'h0, lat, rd);
    checks++;
    if (lat !== 1 || cmd_seen) begin
      errors++; $display("FAIL zero_strobe: lat=%0d cmd=%0d want 1 0", lat, cmd_seen);
    end
    checks++;
    if (mem[14'h0040] !== exp_mem[14'h0040]) begin
      errors++; $display("FAIL zero_strobe_mem: got %h want %h", mem[14'h0040], exp_mem[14'h0040]);
    end
  endtask

  // Both ports request from reset; check order, spacing, done-before-gnt, bus safety
  task automatic test_arbitration();
    int gp[$]; int gc[$]; int cyc; bit outstanding; bit h1, h2; int n;
    preload(14'h0080, 32'hCAFE0080);
    preload(14'h0081, 32'hBEEF0081);
    rst_n = 1'b0;
    drive_port(1'b0, 1'b1, 1'b0, 32'h0000_0200, '0, 4'h0);
    drive_port(1'b1, 1'b1, 1'b0, 32'h0000_0204, '0, 4'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc = 0; outstanding = 0; h1 = 0; h2 = 0;
    while (gp.size() < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (h2) begin
        checks++;
        if (dqs !== 1'b0 || we !== 1'b1) begin
          errors++; $display("FAIL bus_turnaround: dqs=%b we=%b want 0 1", dqs, we);
        end
      end
      h2 = h1;
      h1 = ({cs, ras, cas, we} == 4'b0001);
      if (p0_done || p1_done) begin
        checks++;
        if ((p0_done && p0_rdata !== exp_mem[14'h0080]) ||
            (p1_done && p1_rdata !== exp_mem[14'h0081])) begin
          errors++; $display("FAIL arb_rdata: p0=%h p1=%h want %h %h", p0_rdata, p1_rdata,
                             exp_mem[14'h0080], exp_mem[14'h0081]);
        end
        outstanding = 0;
      end
      if (p0_gnt || p1_gnt) begin
        checks++;
        if (outstanding || (p0_gnt && p1_gnt)) begin
          errors++; $display("FAIL arb_overlap: gnt with pending=%0d both=%0d want 0 0",
                             outstanding, p0_gnt && p1_gnt);
        end
        gp.push_back(p1_gnt ? 1 : 0);
        gc.push_back(cyc);
        outstanding = 1;
      end
    end
    checks++;
    if (gp.size() != 6) begin errors++; $display("FAIL arb_count: got %0d grants want 6", gp.size()); end
    for (int i = 0; i < gp.size(); i++) begin
      checks++;
      if (gp[i] != (i % 2)) begin errors++; $display("FAIL arb_order: grant %0d port %0d want %0d", i, gp[i], i % 2); end
      if (i > 0) begin
        checks++;
        if (gc[i] - gc[i-1] != 4) begin
          errors++; $display("FAIL arb_spacing: grant %0d gap %0d want 4", i, gc[i] - gc[i-1]);
        end
      end
    end
    @(posedge clk); #1;
    p0_req = 1'b0; p1_req = 1'b0;
    n = 0;
    while (busy && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL arb_drain: busy=%b want 0", busy); end
  endtask

  task automatic test_reset_mid_rmw();
    int n; int lat; bit seen; logic [31:0] rd; logic [31:0] want;
    preload(14'h0050, 32'h55667788);
    @(negedge clk);
    drive_port(1'b0, 1'b1, 1'b1, 32'h0000_0140, 32'h99AABBCC, 4'b0011);
    #1; n = 0;
    while (!p0_gnt && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (p0_gnt !== 1'b1) begin errors++; $display("FAIL mid_gnt: gnt=%b want 1", p0_gnt); end
    @(posedge clk); #1;
    p0_req = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({cs, ras, cas, we, dqs, busy} !== 6'b111100 || dm !== 4'h0) begin
      errors++; $display("FAIL mid_reset_pins: got %b dm=%h want 111100 0", {cs, ras, cas, we, dqs, busy}, dm);
    end
    seen = 0;
    repeat (2) begin @(negedge clk); if (p0_done || p1_done) seen = 1; end
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) begin @(negedge clk); if (p0_done || p1_done) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL mid_reset_done: done seen=1 want 0"); end
    checks++;
    if (mem[14'h0050] !== 32'h55667788) begin
      errors++; $display("FAIL mid_reset_mem: got %h want 55667788", mem[14'h0050]);
    end
    do_txn(1'b0, 1'b1, 32'h0000_0140, 32'h99AABBCC, 4'b0011, lat, rd);
    exp_mem[14'h0050] = merge_w(exp_mem[14'h0050], 32'h99AABBCC, 4'b0011);
    want = exp_mem[14'h0050];
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL mid_reissue: lat=%0d want 5", lat); end
    do_txn(1'b1, 1'b0, 32'h0000_0140, '0, 4'h0, lat, rd);
    checks++;
    if (rd !== want) begin errors++; $display("FAIL mid_readback: got %h want %h", rd, want); end
  endtask

  // Random mix against the word-level model; high address bits vary to alias
  task automatic test_random();
    int lat; logic [31:0] rd; logic [31:0] last [0:1]; bit have [0:1];
    bit port; bit w; logic [3:0] s; logic [31:0] a, d; logic [13:0] word;
    have[0] = 0; have[1] = 0; last[0] = '0; last[1] = '0;
    for (int i = 0; i < 8; i++) preload(14'(14'h0100 + 14'(i)), $urandom);
    for (int k = 0; k < 40; k++) begin
      port = 1'($urandom_range(0, 1));
      w    = 1'($urandom_range(0, 1));
      s    = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      word = 14'(14'h0100 + 14'($urandom_range(0, 7)));
      a    = {16'($urandom >> 16), word, 2'($urandom_range(0, 3))};
      d    = $urandom;
      do_txn(port, w, a, d, s, lat, rd);
      checks++;
      if (lat != exp_lat(w, s) || other_done) begin
        errors++;
        $display("FAIL rnd_latency: txn %0d we=%0d strb=%h lat=%0d other=%0d want %0d 0",
                 k, w, s, lat, other_done, exp_lat(w, s));
      end
      if (!w) begin
        checks++;
        if (rd !== exp_mem[word]) begin
          errors++; $display("FAIL rnd_rdata: txn %0d word %h got %h want %h", k, word, rd, exp_mem[word]);
        end
        last[port] = exp_mem[word];
        have[port] = 1;
      end else begin
        exp_mem[word] = merge_w(exp_mem[word], d, s);
        if (have[port]) begin
          checks++;
          if ((port ? p1_rdata : p0_rdata) !== last[port]) begin
            errors++; $display("FAIL rnd_rdata_hold: txn %0d got %h want %h", k,
                               port ? p1_rdata : p0_rdata, last[port]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_full_write_read();
    test_rmw();
    test_zero_strobe();
    test_arbitration();
    test_reset_mid_rmw();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
